// File: rtl/taskwait_cam.sv
// taskwait_cam: tracks outstanding child completions per parent task_id in a
// register CAM. It wakes the waiting accelerator once the signed component
// count for that task returns to zero.
module taskwait_cam #(
   parameter int unsigned MAX_ACCS    = 16,
   parameter int unsigned NUM_ENTRIES = 16,
   parameter int unsigned COMP_BITS   = 32
) (
   input  logic                            clk,
   input  logic                            rstn,
   input  logic [63:0]                     inStream_TDATA,
   input  logic                            inStream_TVALID,
   input  logic [$clog2(MAX_ACCS)-1:0]     inStream_TID,
   output logic                            inStream_TREADY,
   output logic [63:0]                     outStream_TDATA,
   output logic                            outStream_TVALID,
   input  logic                            outStream_TREADY,
   output logic                            outStream_TLAST,
   output logic [$clog2(MAX_ACCS)-1:0]     outStream_TDEST,
   output logic [$clog2(NUM_ENTRIES):0]    occupancy,
   output logic                            err_full,
   output logic                            err_dup,
   input  logic                            clear_err
);

   localparam int unsigned ACC_BITS = $clog2(MAX_ACCS);
   localparam int unsigned IDX_BITS = $clog2(NUM_ENTRIES);
   localparam int unsigned OCC_BITS = IDX_BITS + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_TID,
      S_LOOKUP,
      S_UPDATE,
      S_WAKEUP
   } state_t;

   state_t state;

   // CAM storage
   logic [NUM_ENTRIES-1:0] ent_valid;
   logic [NUM_ENTRIES-1:0] ent_waiter;
   logic [ACC_BITS-1:0]    ent_acc  [NUM_ENTRIES];
   logic [63:0]            ent_task [NUM_ENTRIES];
   logic [COMP_BITS-1:0]   ent_cnt  [NUM_ENTRIES];

   // Latched message fields
   logic [COMP_BITS-1:0] comps_r;
   logic                 typ_r;
   logic [ACC_BITS-1:0]  tid_r;
   logic [63:0]          task_r;

   // Registered lookup results
   logic                 hit_r;
   logic [IDX_BITS-1:0]  hit_idx_r;
   logic [IDX_BITS-1:0]  free_idx_r;
   logic                 full_r;

   // Lookup combinational results
   logic                 hit_c;
   logic [IDX_BITS-1:0]  hit_idx_c;
   logic [IDX_BITS-1:0]  free_idx_c;
   logic                 free_found_c;
   logic                 full_c;

   // Update combinational results
   logic [COMP_BITS-1:0] cur_cnt_c;
   logic [COMP_BITS-1:0] delta_c;
   logic [COMP_BITS-1:0] new_cnt_c;
   logic                 new_zero_c;
   logic                 hit_waiter_c;
   logic [ACC_BITS-1:0]  hit_acc_c;

   // Wake-up beats carry a fixed payload
   assign outStream_TDATA = 64'd1;
   assign outStream_TLAST = 1'b1;

   // Parallel compare against all valid entries, plus lowest free slot
   always_comb begin
      hit_c        = 1'b0;
      hit_idx_c    = '0;
      free_idx_c   = '0;
      free_found_c = 1'b0;
      for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
         if (ent_valid[i] && (ent_task[i] == task_r)) begin
            hit_c     = 1'b1;
            hit_idx_c = IDX_BITS'(i);
         end
         if (!ent_valid[i] && !free_found_c) begin
            free_found_c = 1'b1;
            free_idx_c   = IDX_BITS'(i);
         end
      end
      full_c = &ent_valid;
   end

   // New counter value: WAIT subtracts components, FINISH adds one
   always_comb begin
      cur_cnt_c    = hit_r ? ent_cnt[hit_idx_r] : '0;
      delta_c      = typ_r ? (COMP_BITS'(0) - comps_r) : COMP_BITS'(1);
      new_cnt_c    = cur_cnt_c + delta_c;
      new_zero_c   = (new_cnt_c == '0);
      hit_waiter_c = ent_waiter[hit_idx_r];
      hit_acc_c    = ent_acc[hit_idx_r];
   end

   // Message FSM, CAM update, registered stream outputs and error flags
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state            <= S_IDLE;
         inStream_TREADY  <= 1'b0;
         outStream_TVALID <= 1'b0;
         outStream_TDEST  <= '0;
         occupancy        <= '0;
         err_full         <= 1'b0;
         err_dup          <= 1'b0;
         ent_valid        <= '0;
         ent_waiter       <= '0;
         comps_r          <= '0;
         typ_r            <= 1'b0;
         tid_r            <= '0;
         task_r           <= '0;
         hit_r            <= 1'b0;
         hit_idx_r        <= '0;
         free_idx_r       <= '0;
         full_r           <= 1'b0;
      end else begin
         // Clear first so a set in the same cycle takes precedence
         if (clear_err) begin
            err_full <= 1'b0;
            err_dup  <= 1'b0;
         end

         case (state)
            S_IDLE: begin
               inStream_TREADY <= 1'b1;
               if (inStream_TREADY && inStream_TVALID) begin
                  comps_r <= inStream_TDATA[COMP_BITS-1:0];
                  typ_r   <= inStream_TDATA[32];
                  tid_r   <= inStream_TID;
                  state   <= S_TID;
               end
            end

            S_TID: begin
               if (inStream_TVALID) begin
                  task_r          <= inStream_TDATA;
                  inStream_TREADY <= 1'b0;
                  state           <= S_LOOKUP;
               end
            end

            S_LOOKUP: begin
               hit_r      <= hit_c;
               hit_idx_r  <= hit_idx_c;
               free_idx_r <= free_idx_c;
               full_r     <= full_c;
               state      <= S_UPDATE;
            end

            S_UPDATE: begin
               state           <= S_IDLE;
               inStream_TREADY <= 1'b1;
               if (hit_r) begin
                  if (new_zero_c) begin
                     ent_valid[hit_idx_r]  <= 1'b0;
                     ent_waiter[hit_idx_r] <= 1'b0;
                     occupancy             <= occupancy - OCC_BITS'(1);
                     if (typ_r || hit_waiter_c) begin
                        outStream_TVALID <= 1'b1;
                        outStream_TDEST  <= typ_r ? tid_r : hit_acc_c;
                        inStream_TREADY  <= 1'b0;
                        state            <= S_WAKEUP;
                     end
                  end else begin
                     ent_cnt[hit_idx_r] <= new_cnt_c;
                     if (typ_r) begin
                        if (hit_waiter_c) begin
                           err_dup <= 1'b1;
                        end else begin
                           ent_waiter[hit_idx_r] <= 1'b1;
                           ent_acc[hit_idx_r]    <= tid_r;
                        end
                     end
                  end
               end else if (new_zero_c) begin
                  // Zero-component wait on an unknown task completes at once
                  outStream_TVALID <= 1'b1;
                  outStream_TDEST  <= tid_r;
                  inStream_TREADY  <= 1'b0;
                  state            <= S_WAKEUP;
               end else if (!full_r) begin
                  ent_valid[free_idx_r]  <= 1'b1;
                  ent_waiter[free_idx_r] <= typ_r;
                  ent_acc[free_idx_r]    <= tid_r;
                  ent_task[free_idx_r]   <= task_r;
                  ent_cnt[free_idx_r]    <= new_cnt_c;
                  occupancy              <= occupancy + OCC_BITS'(1);
               end else begin
                  err_full <= 1'b1;
               end
            end

            S_WAKEUP: begin
               if (outStream_TREADY) begin
                  outStream_TVALID <= 1'b0;
                  inStream_TREADY  <= 1'b1;
                  state            <= S_IDLE;
               end
            end

            default: begin
               state           <= S_IDLE;
               inStream_TREADY <= 1'b0;
            end
         endcase
      end
   end

endmodule
